// File: rtl/serial_comp_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_comp_pkg
// Purpose  : Shared types and helpers for the serial two's-complement unit.
//            The package holds the operation mode encoding, the FSM state
//            encoding and the rule that decides whether an operand is negated.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_comp_pkg;

  // Operation mode. MODE_RSVD behaves as MODE_PASS.
  typedef enum logic [1:0] {
    MODE_PASS = 2'd0,
    MODE_NEG  = 2'd1,
    MODE_ABS  = 2'd2,
    MODE_RSVD = 2'd3
  } mode_t;

  // Control FSM state encoding.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // An operand is negated for MODE_NEG, and for MODE_ABS only when it is
  // negative (sign bit set).
  function automatic logic neg_for_mode(input mode_t m, input logic msb);
    return (m == MODE_NEG) | ((m == MODE_ABS) & msb);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_comp_cell.sv
//------------------------------------------------------------------------------
// Module   : serial_comp_cell
// Purpose  : One-bit combinational carry cell for LSB-first two's-complement
//            negation. It computes ~b + carry when negating, and passes the
//            bit through with the carry unchanged otherwise.
// Ports    : b          - current operand bit (LSB first)
//            carry      - incoming carry (1 at the start of an operation)
//            neg        - 1 = negate, 0 = pass through
//            o          - output bit
//            carry_next - carry for the next bit
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_comp_cell (
  input  logic b,
  input  logic carry,
  input  logic neg,
  output logic o,
  output logic carry_next
);

  always_comb begin
    o          = b;
    carry_next = carry;
    if (neg) begin
      // Increment of the inverted bit: the carry survives only while the
      // inverted bits are 1, that is while the original bits are 0.
      o          = ~b ^ carry;
      carry_next = ~b & carry;
    end
  end

endmodule

`default_nettype wire

// File: rtl/serial_twos_comp_unit.sv
//------------------------------------------------------------------------------
// Module   : serial_twos_comp_unit
// Purpose  : Parametrised serial two's-complement unit. It loads a W-bit
//            operand on start, processes it LSB-first one bit per clock through
//            a single carry cell, and returns pass / negate / abs results in
//            parallel with a done pulse. It also streams the result bits out
//            serially.
// Ports    : clk        - rising-edge clock
//            rst        - synchronous active-high reset
//            start      - request, sampled only while idle
//            mode       - 0 pass, 1 negate, 2 abs, 3 pass (latched with start)
//            din        - W-bit operand (latched with start)
//            busy       - operation in progress
//            done       - one-cycle completion pulse
//            result     - completed result, held until the next operation ends
//            ovf        - set when the most-negative value was negated
//            sout       - serial result bit, LSB first
//            sout_valid - qualifies sout
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_twos_comp_unit
  import serial_comp_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [W-1:0] din,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] result,
  output logic         ovf,
  output logic         sout,
  output logic         sout_valid
);

  localparam int             CW     = $clog2(W);
  localparam logic [CW-1:0]  C_LAST = CW'(W - 1);
  // Most-negative W-bit value: the only operand that negates onto itself.
  localparam logic [W-1:0]   C_MIN  = {1'b1, {(W-1){1'b0}}};

  state_t        r_state;
  logic [W-1:0]  r_sr;
  logic          r_carry;
  logic          r_neg;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic [W-1:0]  r_result;
  logic          r_ovf;
  logic          r_sout;
  logic          r_sout_valid;

  logic          w_o;
  logic          w_carry_next;
  logic          w_neg_load;
  logic [W-1:0]  w_next_sr;
  logic          w_ovf;

  serial_comp_cell u_cell (
    .b          (r_sr[0]),
    .carry      (r_carry),
    .neg        (r_neg),
    .o          (w_o),
    .carry_next (w_carry_next)
  );

  assign w_neg_load = neg_for_mode(mode_t'(mode), din[W-1]);

  // Right shift with the freshly computed bit entering at the MSB. After W
  // shifts the register holds the complete result.
  assign w_next_sr  = {w_o, r_sr[W-1:1]};

  // When negating, only the most-negative operand yields the most-negative
  // result, so checking the final value detects the overflow case exactly.
  assign w_ovf      = r_neg & (w_next_sr == C_MIN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_sr         <= '0;
      r_carry      <= 1'b1;
      r_neg        <= 1'b0;
      r_cnt        <= '0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_result     <= '0;
      r_ovf        <= 1'b0;
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
    end else begin
      r_done       <= 1'b0;
      r_sout_valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sr    <= din;
            r_carry <= 1'b1;
            r_cnt   <= '0;
            r_neg   <= w_neg_load;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sr         <= w_next_sr;
          r_carry      <= w_carry_next;
          r_sout       <= w_o;
          r_sout_valid <= 1'b1;
          r_cnt        <= r_cnt + CW'(1);
          if (r_cnt == C_LAST) begin
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_result <= w_next_sr;
            r_ovf    <= w_ovf;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign result     = r_result;
  assign ovf        = r_ovf;
  assign sout       = r_sout;
  assign sout_valid = r_sout_valid;

endmodule

`default_nettype wire

// File: tb/tb_serial_twos_comp_unit.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_twos_comp_unit
// Purpose  : Self-checking bench for serial_twos_comp_unit with W=8 and W=4
//            instances. Expected parallel results and serial bits are queued
//            when an operation is started and compared when the DUT emits them.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_twos_comp_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  logic       s8;
  logic [1:0] m8;
  logic [7:0] d8;
  logic       busy8, done8, ovf8, sout8, sv8;
  logic [7:0] res8;

  logic       s4;
  logic [1:0] m4;
  logic [3:0] d4;
  logic       busy4, done4, ovf4, sout4, sv4;
  logic [3:0] res4;

  serial_twos_comp_unit #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .mode(m8), .din(d8),
    .busy(busy8), .done(done8), .result(res8), .ovf(ovf8),
    .sout(sout8), .sout_valid(sv8)
  );

  serial_twos_comp_unit #(.W(4)) dut4 (
    .clk(clk), .rst(rst), .start(s4), .mode(m4), .din(d4),
    .busy(busy4), .done(done4), .result(res4), .ovf(ovf4),
    .sout(sout4), .sout_valid(sv4)
  );

  typedef struct {
    logic [7:0] res;
    logic       ovf;
  } exp_t;

  exp_t exp8[$];
  exp_t exp4[$];
  logic bq8[$];
  logic bq4[$];

  int checks = 0;
  int errors = 0;
  int dones8 = 0;

  // Reference model: negation by two's-complement arithmetic, truncated to w.
  function automatic exp_t model(input int w, input logic [1:0] mode, input logic [7:0] din);
    exp_t       e;
    logic [7:0] mask;
    logic [7:0] minv;
    logic       neg;
    mask  = 8'((16'd1 << w) - 16'd1);
    minv  = 8'(16'd1 << (w - 1));
    neg   = (mode == 2'd1) || ((mode == 2'd2) && ((din & minv) != 8'd0));
    e.res = neg ? ((8'd0 - din) & mask) : (din & mask);
    e.ovf = neg && (din == minv);
    return e;
  endfunction

  // ---------------- output monitors (sample on falling edge) ----------------
  always @(negedge clk) begin
    exp_t e;
    logic b;
    if (sv8) begin
      checks++;
      if (bq8.size() == 0) begin
        errors++;
        $error("FAIL sout8: unexpected valid bit, observed %b, expected none", sout8);
      end else begin
        b = bq8.pop_front();
        assert (sout8 === b) else begin
          errors++;
          $error("FAIL sout8: observed %b expected %b", sout8, b);
        end
      end
    end
    if (done8) begin
      dones8++;
      checks++;
      if (exp8.size() == 0) begin
        errors++;
        $error("FAIL done8: unexpected done, observed result %h", res8);
      end else begin
        e = exp8.pop_front();
        assert (res8 === e.res) else begin
          errors++;
          $error("FAIL result8: observed %h expected %h", res8, e.res);
        end
        checks++;
        assert (ovf8 === e.ovf) else begin
          errors++;
          $error("FAIL ovf8: observed %b expected %b", ovf8, e.ovf);
        end
        checks++;
        assert (busy8 === 1'b0) else begin
          errors++;
          $error("FAIL busy8_at_done: observed %b expected 0", busy8);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    logic b;
    if (sv4) begin
      checks++;
      if (bq4.size() == 0) begin
        errors++;
        $error("FAIL sout4: unexpected valid bit, observed %b, expected none", sout4);
      end else begin
        b = bq4.pop_front();
        assert (sout4 === b) else begin
          errors++;
          $error("FAIL sout4: observed %b expected %b", sout4, b);
        end
      end
    end
    if (done4) begin
      checks++;
      if (exp4.size() == 0) begin
        errors++;
        $error("FAIL done4: unexpected done, observed result %h", res4);
      end else begin
        e = exp4.pop_front();
        assert (res4 === e.res[3:0]) else begin
          errors++;
          $error("FAIL result4: observed %h expected %h", res4, e.res[3:0]);
        end
        checks++;
        assert (ovf4 === e.ovf) else begin
          errors++;
          $error("FAIL ovf4: observed %b expected %b", ovf4, e.ovf);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push8(input logic [1:0] mode, input logic [7:0] din);
    exp_t e;
    e = model(8, mode, din);
    exp8.push_back(e);
    for (int i = 0; i < 8; i++) bq8.push_back(e.res[i]);
  endtask

  task automatic push4(input logic [1:0] mode, input logic [3:0] din);
    exp_t e;
    e = model(4, mode, {4'd0, din});
    exp4.push_back(e);
    for (int i = 0; i < 4; i++) bq4.push_back(e.res[i]);
  endtask

  // Starts a W=8 operation at the current falling edge and waits for done.
  // Returns with the bench sitting on the falling edge of the done cycle.
  task automatic go8(input logic [1:0] mode, input logic [7:0] din, input string tag);
    int n;
    s8 = 1'b1; m8 = mode; d8 = din;
    push8(mode, din);
    @(negedge clk);
    s8 = 1'b0;
    n  = 1;
    checks++;
    assert (busy8 === 1'b1) else begin
      errors++;
      $error("FAIL %s_busy: observed %b expected 1", tag, busy8);
    end
    while (!done8 && n < 40) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (done8 === 1'b1 && n == 9) else begin
      errors++;
      $error("FAIL %s_latency: observed %0d edges (done=%b) expected 9", tag, n, done8);
    end
  endtask

  task automatic hold8(input logic [7:0] r, input logic o, input string tag);
    repeat (2) @(negedge clk);
    checks++;
    assert (res8 === r && ovf8 === o && done8 === 1'b0 && sv8 === 1'b0) else begin
      errors++;
      $error("FAIL %s_hold: observed res=%h ovf=%b done=%b sv=%b expected res=%h ovf=%b done=0 sv=0",
             tag, res8, ovf8, done8, sv8, r, o);
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    int d0;
    rst = 1'b1;
    s8 = 1'b0; m8 = 2'd0; d8 = 8'd0;
    s4 = 1'b0; m4 = 2'd0; d4 = 4'd0;
    repeat (3) @(negedge clk);

    checks++;
    assert ({busy8, done8, res8, ovf8, sout8, sv8} === 13'd0) else begin
      errors++;
      $error("FAIL reset8: observed %b expected all zero", {busy8, done8, res8, ovf8, sout8, sv8});
    end
    checks++;
    assert ({busy4, done4, res4, ovf4, sout4, sv4} === 9'd0) else begin
      errors++;
      $error("FAIL reset4: observed %b expected all zero", {busy4, done4, res4, ovf4, sout4, sv4});
    end
    rst = 1'b0;
    @(negedge clk);

    // W=8 directed cases
    go8(2'd1, 8'h05, "neg05");
    hold8(8'hFB, 1'b0, "neg05");
    go8(2'd2, 8'hF6, "absF6");
    go8(2'd2, 8'h3C, "abs3C");
    go8(2'd1, 8'h80, "neg80");
    hold8(8'h80, 1'b1, "neg80");
    go8(2'd1, 8'h00, "neg00");
    go8(2'd3, 8'hA5, "rsvdA5");

    // W=4 back-to-back with start in the done cycle and ignored mid-SHIFT starts
    @(negedge clk);
    s4 = 1'b1; m4 = 2'd0; d4 = 4'hA;
    push4(2'd0, 4'hA);
    @(negedge clk);
    s4 = 1'b0;
    n = 1;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (done4 === 1'b1 && n == 5) else begin
      errors++;
      $error("FAIL w4_first_latency: observed %0d (done=%b) expected 5", n, done4);
    end
    s4 = 1'b1; m4 = 2'd1; d4 = 4'h3;
    push4(2'd1, 4'h3);
    @(negedge clk);
    s4 = 1'b0;
    n = 1;
    @(negedge clk);
    n++;
    s4 = 1'b1; m4 = 2'd0; d4 = 4'hF;
    @(negedge clk);
    n++;
    s4 = 1'b0;
    while (!done4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (done4 === 1'b1 && n == 5) else begin
      errors++;
      $error("FAIL w4_b2b_spacing: observed %0d (done=%b) expected 5", n, done4);
    end
    repeat (8) @(negedge clk);
    checks++;
    assert (busy4 === 1'b0 && res4 === 4'hD && exp4.size() == 0) else begin
      errors++;
      $error("FAIL w4_ignored_start: observed busy=%b res=%h pending=%0d expected busy=0 res=d pending=0",
             busy4, res4, exp4.size());
    end

    // W=8 reset in the fourth SHIFT cycle
    s8 = 1'b1; m8 = 2'd1; d8 = 8'h55;
    push8(2'd1, 8'h55);
    @(negedge clk);
    s8 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp8.delete();
    bq8.delete();
    checks++;
    assert ({busy8, done8, res8, ovf8, sout8, sv8} === 13'd0) else begin
      errors++;
      $error("FAIL abort_reset: observed %b expected all zero", {busy8, done8, res8, ovf8, sout8, sv8});
    end
    d0 = dones8;
    repeat (12) @(negedge clk);
    checks++;
    assert (dones8 == d0 && busy8 === 1'b0) else begin
      errors++;
      $error("FAIL abort_no_done: observed %0d dones busy=%b expected 0 dones busy=0", dones8 - d0, busy8);
    end

    go8(2'd1, 8'h01, "neg01");
    hold8(8'hFF, 1'b0, "neg01");

    repeat (3) @(negedge clk);
    checks++;
    assert (exp8.size() == 0 && bq8.size() == 0 && bq4.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed pending %0d/%0d/%0d expected 0/0/0", exp8.size(), bq8.size(), bq4.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
